ram_stream_fifo: RTL and testbench



---
 rtl/ram_stream_fifo.sv | 135 +++++++++++++
 tb/tb_ram_stream_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_fifo.sv
// First-word-fall-through FIFO on a pipelined single-clock RAM.
// A small prefetch buffer of RAM_LATENCY+1 words sits behind the RAM.
// Reads are issued ahead of demand, so the read latency is hidden and the
// FIFO can stream one word per cycle.
//
// Handshakes: a transfer happens on an edge where valid && ready. in_ready
// is built only from the registered count and rst/flush. out_valid/out_data
// come straight from the buffer head registers. Neither side depends
// combinationally on the other side's valid or ready.
module ram_stream_fifo #(
  parameter int WIDTH       = 512,
  parameter int DEPTH       = 4096,
  parameter int RAM_LATENCY = 3,
  parameter int ALMOST_FULL = DEPTH - 4
) (
  input  logic                     core_clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NB = RAM_LATENCY + 1;
  localparam int BW = $clog2(NB + 1) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);
  localparam logic [BW-1:0] NB_C    = BW'(NB);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] pipe_data_q [RAM_LATENCY];

  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          ram_cnt_q, ram_cnt_d;   // words in RAM, not yet read-issued
  logic [BW-1:0]          fl_cnt_q, fl_cnt_d;     // reads in flight
  logic [BW-1:0]          buf_cnt_q, buf_cnt_d;   // words held in prefetch buffer
  logic [RAM_LATENCY-1:0] pipe_v_q, pipe_v_d;     // per-stage read valid, cleared to kill reads
  logic [WIDTH-1:0]       buf_q [NB];
  logic [WIDTH-1:0]       buf_d [NB];

  logic          push, pop, issue, land;
  logic [BW-1:0] occ, wr_idx;

  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AF_C);
  assign count       = count_q;
  assign in_ready    = !full && !rst && !flush;
  assign out_valid   = (buf_cnt_q != '0);
  assign out_data    = buf_q[0];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && !flush;
  assign land = pipe_v_q[RAM_LATENCY-1];
  // A pop this cycle frees a slot, so a new read can issue at the same edge.
  assign occ    = fl_cnt_q + buf_cnt_q - BW'(pop);
  assign issue  = (ram_cnt_q != '0) && (occ < NB_C) && !flush;
  assign wr_idx = buf_cnt_q - BW'(pop);

  // Next-state computation for pointers, counters, read pipeline and buffer
  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(issue);
    ram_cnt_d = ram_cnt_q + CW'(push) - CW'(issue);
    fl_cnt_d  = fl_cnt_q + BW'(issue) - BW'(land);
    buf_cnt_d = buf_cnt_q - BW'(pop) + BW'(land);
    count_d   = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;

    pipe_v_d[0] = issue;
    for (int i = 1; i < RAM_LATENCY; i++) pipe_v_d[i] = pipe_v_q[i-1];

    // Shift the buffer on pop. Returned data then lands at the first free slot.
    for (int i = 0; i < NB - 1; i++) buf_d[i] = pop ? buf_q[i+1] : buf_q[i];
    buf_d[NB-1] = pop ? '0 : buf_q[NB-1];
    for (int i = 0; i < NB; i++) begin
      if (land && (wr_idx == BW'(i))) buf_d[i] = pipe_data_q[RAM_LATENCY-1];
    end

    // Flush clears everything but the RAM. Clearing pipe_v kills in-flight reads.
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
      fl_cnt_d  = '0;
      buf_cnt_d = '0;
      count_d   = '0;
      pipe_v_d  = '0;
      for (int i = 0; i < NB; i++) buf_d[i] = '0;
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge core_clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      fl_cnt_q  <= '0;
      buf_cnt_q <= '0;
      count_q   <= '0;
      pipe_v_q  <= '0;
      for (int i = 0; i < NB; i++) buf_q[i] <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
      buf_cnt_q <= buf_cnt_d;
      count_q   <= count_d;
      pipe_v_q  <= pipe_v_d;
      for (int i = 0; i < NB; i++) buf_q[i] <= buf_d[i];
    end
  end

  // RAM array plus read data pipeline. There is no reset, so block RAM can be inferred.
  always_ff @(posedge core_clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
    pipe_data_q[0] <= mem[rd_ptr_q];
    for (int i = 1; i < RAM_LATENCY; i++) pipe_data_q[i] <= pipe_data_q[i-1];
  end

endmodule

// File: tb/tb_ram_stream_fifo.sv
// Bench for ram_stream_fifo with DEPTH=16, RAM_LATENCY=3, ALMOST_FULL=12.
// The reference model is a word queue. Each entry carries the edge number
// at which it was accepted. The head word is visible exactly RAM_LATENCY+1
// edges after its accept edge, and the count is the queue length.
module tb_ram_stream_fifo;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int L  = 3;
  localparam int AF = 12;

  logic         core_clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [4:0]   count;
  logic         empty, full, almost_full;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  logic [W-1:0] exp_q[$];
  int           exp_e[$];

  ram_stream_fifo #(.WIDTH(W), .DEPTH(D), .RAM_LATENCY(L), .ALMOST_FULL(AF)) dut (
    .core_clk(core_clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full)
  );

  // Clock
  always #5 core_clk = ~core_clk;

  function automatic logic exp_valid();
    return (exp_q.size() > 0) && (exp_e[0] + L + 1 <= edge_n);
  endfunction

  // Driver: present one cycle of stimulus, advance one edge, update the model.
  task automatic tick(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    logic do_push, do_pop;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    do_push = iv && (exp_q.size() < D) && !fl;
    do_pop  = exp_valid() && ordy && !fl;
    @(posedge core_clk);
    edge_n++;
    if (fl) begin
      exp_q.delete(); exp_e.delete();
    end else begin
      if (do_pop) begin void'(exp_q.pop_front()); void'(exp_e.pop_front()); end
      if (do_push) begin exp_q.push_back(d); exp_e.push_back(edge_n); end
    end
    #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
    repeat (2) @(posedge core_clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL reset_flags got full=%b af=%b exp 0 0", full, almost_full); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got %b exp 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL reset_no_write got v=%b cnt=%0d exp 0 0", out_valid, count); end
    end
  endtask

  task automatic test_single();
    int e0, first;
    first = -1;
    tick(1'b1, 16'h00A5, 1'b1, 1'b0);
    e0 = edge_n;
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_valid !== exp_valid()) begin errors++; $display("FAIL single_valid got %b exp %b", out_valid, exp_valid()); end
      if (out_valid === 1'b1 && first < 0) begin
        first = edge_n - e0;
        checks++; if (out_data !== 16'h00A5) begin errors++; $display("FAIL single_data got %h exp 00a5", out_data); end
      end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
    checks++; if (first != L + 1) begin errors++; $display("FAIL single_latency got %0d exp %0d", first, L + 1); end
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_count got %0d empty=%b exp 0 1", count, empty); end
  endtask

  task automatic test_fill();
    int idx, k;
    idx = 0;
    for (int c = 0; c < 22; c++) begin
      logic pushed;
      pushed = (idx < 18) && (exp_q.size() < D);
      tick(idx < 18, W'(idx), 1'b0, 1'b0);
      if (pushed) idx++;
      checks++; if (almost_full !== (exp_q.size() >= AF)) begin errors++; $display("FAIL fill_af got %b size %0d", almost_full, exp_q.size()); end
      checks++; if (full !== (exp_q.size() == D) || in_ready !== (exp_q.size() < D)) begin errors++; $display("FAIL fill_full got full=%b rdy=%b size %0d", full, in_ready, exp_q.size()); end
      checks++; if (int'(count) !== exp_q.size()) begin errors++; $display("FAIL fill_count got %0d exp %0d", count, exp_q.size()); end
    end
    checks++; if (idx != 16) begin errors++; $display("FAIL fill_accepted got %0d exp 16", idx); end
    k = 0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      checks++; if (out_valid !== exp_valid()) begin errors++; $display("FAIL drain_valid got %b exp %b", out_valid, exp_valid()); end
      if (exp_valid()) begin
        checks++; if (out_data !== W'(k)) begin errors++; $display("FAIL drain_data got %h exp %h", out_data, W'(k)); end
        k++;
      end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
    checks++; if (k != 16) begin errors++; $display("FAIL drain_pops got %0d exp 16", k); end
  endtask

  task automatic test_stream(input int n, input bit wrap_mode);
    int sent, cyc;
    sent = 0; cyc = 0;
    while ((sent < n || exp_q.size() > 0) && cyc < 20000) begin
      logic iv, ordy, pushed;
      checks++; if (out_valid !== exp_valid()) begin errors++; $display("FAIL stream_valid cyc %0d got %b exp %b", cyc, out_valid, exp_valid()); end
      if (exp_valid()) begin
        checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL stream_data cyc %0d got %h exp %h", cyc, out_data, exp_q[0]); end
      end
      checks++; if (int'(count) !== exp_q.size()) begin errors++; $display("FAIL stream_count cyc %0d got %0d exp %0d", cyc, count, exp_q.size()); end
      checks++; if (in_ready !== (exp_q.size() < D)) begin errors++; $display("FAIL stream_in_ready cyc %0d got %b", cyc, in_ready); end
      if (wrap_mode) begin
        iv   = (sent < n);
        ordy = ((exp_q.size() > 10) || sent >= n) && ($urandom_range(0, 3) != 0);
      end else begin
        iv   = (sent < n) && ($urandom_range(0, 1) == 1);
        ordy = ($urandom_range(0, 1) == 1);
      end
      pushed = iv && (exp_q.size() < D);
      tick(iv, W'($urandom), ordy, 1'b0);
      if (pushed) sent++;
      cyc++;
    end
    checks++; if (cyc >= 20000) begin errors++; $display("FAIL stream_timeout sent %0d left %0d", sent, exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int s, sent, pops;
    s = edge_n; sent = 0; pops = 0;
    for (int c = 0; c < 110; c++) begin
      if (edge_n - s >= L + 2 && edge_n - s <= L + 101) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_bubble at %0d got %b exp 1", edge_n - s, out_valid); end
      end
      if (exp_valid()) begin
        checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL b2b_data got %h exp %h", out_data, exp_q[0]); end
      end
      if (out_valid === 1'b1) pops++;
      tick(sent < 100, W'(16'h4000 + sent), 1'b1, 1'b0);
      if (sent < 100) sent++;
    end
    checks++; if (pops != 100 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_pops got %0d exp 100", pops); end
  endtask

  task automatic test_flush();
    int popped, seen;
    logic [W-1:0] first_word;
    for (int i = 0; i < 8; i++) tick(1'b1, W'(16'h0100 + i), 1'b0, 1'b0);
    popped = 0;
    for (int c = 0; c < 20 && popped < 2; c++) begin
      if (exp_valid()) begin
        checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL flush_pre_data got %h exp %h", out_data, exp_q[0]); end
        popped++;
      end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
    checks++; if (popped != 2) begin errors++; $display("FAIL flush_prepops got %0d exp 2", popped); end
    flush = 1'b1; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    tick(1'b1, 16'hBEEF, 1'b1, 1'b1);
    checks++; if (count !== 5'd0 || out_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL flush_clear got cnt=%0d v=%b e=%b exp 0 0 1", count, out_valid, empty); end
    tick(1'b1, 16'h0077, 1'b0, 1'b0);
    seen = 0; first_word = '0;
    for (int c = 0; c < 12; c++) begin
      checks++; if (out_valid !== exp_valid()) begin errors++; $display("FAIL flush_post_valid got %b exp %b", out_valid, exp_valid()); end
      if (out_valid === 1'b1) begin
        if (seen == 0) first_word = out_data;
        seen++;
      end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
    checks++; if (seen != 1 || first_word !== 16'h0077) begin errors++; $display("FAIL flush_post_word got n=%0d word=%h exp 1 0077", seen, first_word); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream(1000, 1'b0);
    test_back_to_back();
    test_stream(50, 1'b1);
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
